scroll_counter_ctrl: RTL and testbench

Sequencer for one 9-bit tilemap scroll counter (`n9bit_counter`-style datapath with `load_n`/`ent_n`/`enp_n`/`direction`/`P`, acting on rising edges of `cen`).
- Holds a CPU-written scroll value in a shadow register and commits it to the active register at vblank.
- Once per line, at hblank start, drives a parallel load of the active scroll value plus offset.
- Enables counting only during active display.
- Sits between the CPU scroll-register decode and the video-layer counters.

---
 rtl/scroll_ctrl_pkg.sv | 26 ++
 rtl/tick_edge_detect.sv | 22 ++
 rtl/scroll_counter_ctrl.sv | 150 +++++++++++++++
 tb/tb_scroll_counter_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_ctrl_pkg.sv
// Shared types and constants for the tilemap scroll counter sequencer.
// Optional flip support is enabled by defining SCROLL_CTRL_FLIP_EN.
package scroll_ctrl_pkg;

  localparam int unsigned SCROLL_W = 9;

  localparam logic SCRL_LO = 1'b0;
  localparam logic SCRL_HI = 1'b1;

  typedef enum logic [1:0] {
    WAIT_HB = 2'd0,
    LOAD    = 2'd1,
    BLANK   = 2'd2,
    RUN     = 2'd3
  } state_e;

  // Scroll value plus offset, wrapped to the counter width and optionally inverted for flip.
  function automatic logic [SCROLL_W-1:0] load_value(input logic [SCROLL_W-1:0] active,
                                                      input logic [SCROLL_W-1:0] offset,
                                                      input logic                inv);
    logic [SCROLL_W-1:0] sum;
    sum = SCROLL_W'(active + offset);
    return inv ? ~sum : sum;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for a level pixel enable; history resets high so the
// first cycle after reset can never produce a tick.
module tick_edge_detect (
  input  logic clk,
  input  logic Reset,
  input  logic cen_i,
  output logic tick_c_o
);

  logic cen_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      cen_q <= 1'b1;
    end else begin
      cen_q <= cen_i;
    end
  end

  assign tick_c_o = cen_i & ~cen_q;

endmodule

// File: rtl/scroll_counter_ctrl.sv
// Sequencer for one 9-bit scroll counter: shadow/active scroll registers, vblank
// commit and per-line load/count control. Define SCROLL_CTRL_FLIP_EN for flip support.
module scroll_counter_ctrl
  import scroll_ctrl_pkg::*;
#(
  parameter logic [SCROLL_W-1:0] OFFSET = 9'd0
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                cen,
  input  logic                hblank,
  input  logic                vblank,
  input  logic                flip,
  input  logic                pause,
  input  logic                cpu_wr,
  input  logic                cpu_addr,
  input  logic [7:0]          cpu_din,
  output logic                cnt_load_n,
  output logic                cnt_ent_n,
  output logic                cnt_enp_n,
  output logic                cnt_dir,
  output logic [SCROLL_W-1:0] cnt_p,
  output logic                pending
);

  logic                tick;
  logic                hb_q, vb_q;
  logic                hb_rise, vb_rise;
  logic                commit;
  logic                flip_v;
  state_e              state_q, state_d;
  logic [SCROLL_W-1:0] shadow_q, shadow_d;
  logic [SCROLL_W-1:0] active_q, active_d;
  logic                pending_q, pending_d;
  logic                load_n_q, load_n_d;
  logic                ent_n_q, ent_n_d;
  logic                enp_n_q, enp_n_d;
  logic [SCROLL_W-1:0] p_q, p_d;

  tick_edge_detect u_tick (
    .clk      (clk),
    .Reset    (Reset),
    .cen_i    (cen),
    .tick_c_o (tick)
  );

`ifdef SCROLL_CTRL_FLIP_EN
  logic dir_q;

  assign flip_v = flip;

  always_ff @(posedge clk) begin
    if (Reset) begin
      dir_q <= 1'b1;
    end else if (tick) begin
      dir_q <= ~flip;
    end
  end

  assign cnt_dir = dir_q;
`else
  logic unused_flip;

  assign unused_flip = flip;
  assign flip_v      = 1'b0;
  assign cnt_dir     = 1'b1;
`endif

  // Blank edges are judged against the previous tick's sample, not the previous clk.
  assign hb_rise = hblank & ~hb_q;
  assign vb_rise = vblank & ~vb_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      hb_q      <= 1'b0;
      vb_q      <= 1'b0;
      state_q   <= WAIT_HB;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      load_n_q  <= 1'b1;
      ent_n_q   <= 1'b1;
      enp_n_q   <= 1'b1;
      p_q       <= '0;
    end else begin
      if (tick) begin
        hb_q <= hblank;
        vb_q <= vblank;
      end
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      load_n_q  <= load_n_d;
      ent_n_q   <= ent_n_d;
      enp_n_q   <= enp_n_d;
      p_q       <= p_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    load_n_d  = load_n_q;
    ent_n_d   = ent_n_q;
    enp_n_d   = enp_n_q;
    p_d       = p_q;
    commit    = tick & vb_rise & pending_q;

    // Commit reads the pre-write shadow; a same-clk CPU write keeps pending set.
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (cpu_wr) begin
      if (cpu_addr == SCRL_LO) begin
        shadow_d[7:0] = cpu_din;
      end else begin
        shadow_d[SCROLL_W-1] = cpu_din[0];
      end
      pending_d = 1'b1;
    end

    if (tick) begin
      unique case (state_q)
        WAIT_HB: if (hb_rise) state_d = LOAD;
        LOAD:    state_d = hblank ? BLANK : RUN;
        BLANK:   if (!hblank) state_d = RUN;
        RUN:     if (hb_rise) state_d = LOAD;
        default: state_d = WAIT_HB;
      endcase

      load_n_d = (state_d != LOAD);
      ent_n_d  = (state_d != RUN);
      enp_n_d  = (state_d == RUN) ? pause : 1'b1;
      if (state_d == LOAD) begin
        p_d = load_value(active_q, OFFSET, flip_v);
      end
    end
  end

  assign cnt_load_n = load_n_q;
  assign cnt_ent_n  = ent_n_q;
  assign cnt_enp_n  = enp_n_q;
  assign cnt_p      = p_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_scroll_counter_ctrl.sv
// Scoreboard bench for scroll_counter_ctrl: a behavioural model predicts the
// outputs after every clk; a negedge monitor compares them against the DUT.
module tb_scroll_counter_ctrl;

  localparam logic [8:0] OFF = 9'd500;

  logic       clk = 1'b0;
  logic       Reset, cen, hblank, vblank, flip, pause, cpu_wr, cpu_addr;
  logic [7:0] cpu_din;
  logic       cnt_load_n, cnt_ent_n, cnt_enp_n, cnt_dir, pending;
  logic [8:0] cnt_p;

  always #5 clk = ~clk;

  scroll_counter_ctrl #(.OFFSET(OFF)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .cen        (cen),
    .hblank     (hblank),
    .vblank     (vblank),
    .flip       (flip),
    .pause      (pause),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cnt_load_n (cnt_load_n),
    .cnt_ent_n  (cnt_ent_n),
    .cnt_enp_n  (cnt_enp_n),
    .cnt_dir    (cnt_dir),
    .cnt_p      (cnt_p),
    .pending    (pending)
  );

  typedef logic [13:0] exp_t;
  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

`ifdef SCROLL_CTRL_FLIP_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  // Model: phase 0 = waiting for hblank, 1 = loading, 2 = blanking, 3 = counting.
  bit m_cen_prev, m_hb_prev, m_vb_prev, m_pend;
  bit m_load_n, m_ent_n, m_enp_n, m_dir;
  int m_shadow, m_active, m_phase, m_p;

  function automatic void model_reset();
    m_cen_prev = 1'b1;
    m_hb_prev  = 1'b0;
    m_vb_prev  = 1'b0;
    m_pend     = 1'b0;
    m_shadow   = 0;
    m_active   = 0;
    m_phase    = 0;
    m_load_n   = 1'b1;
    m_ent_n    = 1'b1;
    m_enp_n    = 1'b1;
    m_dir      = 1'b1;
    m_p        = 0;
  endfunction

  function automatic void model_step();
    bit is_tick, hb_rise, vb_rise;
    int v;
    is_tick = cen && !m_cen_prev;
    if (Reset) begin
      model_reset();
    end else begin
      m_cen_prev = cen;
      if (is_tick) begin
        hb_rise = hblank && !m_hb_prev;
        vb_rise = vblank && !m_vb_prev;
        v = (m_active + int'(OFF)) % 512;
        if (FLIP_EN && flip) v = 511 - v;
        case (m_phase)
          0: if (hb_rise) m_phase = 1;
          1: m_phase = hblank ? 2 : 3;
          2: if (!hblank) m_phase = 3;
          default: if (hb_rise) m_phase = 1;
        endcase
        m_load_n = (m_phase != 1);
        m_ent_n  = (m_phase != 3);
        m_enp_n  = (m_phase == 3) ? pause : 1'b1;
        if (m_phase == 1) m_p = v;
        if (FLIP_EN) m_dir = !flip;
        if (vb_rise && m_pend) begin
          m_active = m_shadow;
          m_pend   = 1'b0;
        end
        m_hb_prev = hblank;
        m_vb_prev = vblank;
      end
      if (cpu_wr) begin
        if (!cpu_addr) m_shadow = (m_shadow & 256) | int'(cpu_din);
        else           m_shadow = (m_shadow & 255) | (int'(cpu_din[0]) << 8);
        m_pend = 1'b1;
      end
    end
    exp_q.push_back({m_load_n, m_ent_n, m_enp_n, m_dir, 9'(m_p), m_pend});
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {cnt_load_n, cnt_ent_n, cnt_enp_n, cnt_dir, cnt_p, pending};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t {load_n,ent_n,enp_n,dir,p,pending}: got %b_%b_%b_%b_%h_%b expected %b_%b_%b_%b_%h_%b",
                 $time, a[13], a[12], a[11], a[10], a[9:1], a[0],
                 e[13], e[12], e[11], e[10], e[9:1], e[0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cpu_write(input bit addr, input logic [7:0] din);
    cpu_wr = 1'b1; cpu_addr = addr; cpu_din = din;
    cyc();
    cpu_wr = 1'b0;
  endtask

  // One low cycle then one high cycle of cen; optional CPU write on the tick clk.
  task automatic tick1(input bit hb, input bit vb, input bit wr, input bit addr,
                       input logic [7:0] din);
    cen = 1'b0; hblank = hb; vblank = vb; cpu_wr = 1'b0;
    cyc();
    cen = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_din = din;
    cyc();
    cpu_wr = 1'b0;
  endtask

  task automatic rand_cpu();
    cpu_wr   = ($urandom % 10) == 0;
    cpu_addr = 1'($urandom);
    cpu_din  = 8'($urandom);
  endtask

  task automatic video(input int nticks, input bit allow_rst);
    int hpos = 0;
    int line = 1;
    for (int t = 0; t < nticks; t++) begin
      hpos++;
      if (hpos == 10) begin hpos = 0; line++; end
      hblank = hpos < 3;
      vblank = (line % 5) == 0;
      pause  = ($urandom % 4) == 0;
      if ($urandom % 40 == 0) flip = ~flip;
      cen = 1'b0;
      repeat ($urandom_range(1, 3)) begin rand_cpu(); cyc(); end
      cen = 1'b1;
      repeat ($urandom_range(1, 3)) begin rand_cpu(); cyc(); end
      cpu_wr = 1'b0;
      if (allow_rst && ($urandom % 150) == 0) begin
        Reset = 1'b1; cyc(); Reset = 1'b0;
      end
    end
  endtask

  initial begin
    Reset = 1'b1; cen = 1'b1; hblank = 1'b0; vblank = 1'b0; flip = 1'b0;
    pause = 1'b0; cpu_wr = 1'b0; cpu_addr = 1'b0; cpu_din = 8'h00;
    repeat (2) cyc();
    Reset = 1'b0;

    // cen toggling every 4 clk with no hblank: enables stay high, cnt_p stays 0.
    for (int i = 0; i < 40; i++) begin
      cen = (i / 4) % 2 == 1;
      cyc();
    end

    // Write 0x134, commit on vblank rise, then load on hblank rise.
    cpu_write(1'b0, 8'h34);
    cpu_write(1'b1, 8'h01);
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick1(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    tick1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Shadow 0x010, then a write lands on the same clk as the commit tick.
    cpu_write(1'b0, 8'h10);
    cpu_write(1'b1, 8'h00);
    tick1(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
    tick1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // active = 20 with OFFSET 500 wraps to 8 (inverted 0x1F7 under flip).
    cpu_write(1'b0, 8'd20);
    cpu_write(1'b1, 8'h00);
    flip = 1'b1;
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    flip = 1'b0;
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Pause for 3 ticks in RUN, then another load, then reset mid-run.
    pause = 1'b1;
    repeat (3) tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    pause = 1'b0;
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    Reset = 1'b1; cyc(); Reset = 1'b0;
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // cen held high for many clk yields a single tick.
    cen = 1'b0; hblank = 1'b1; cyc();
    cen = 1'b1; repeat (12) cyc();

    video(1200, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
